// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 16;
    localparam int BE_W      = 2;
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAITDATA = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    // Latched copy of a requester's command, taken at grant time.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } arb_req_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and Avalon-MM-side signal bundle of the arbiter.
interface sdram_arbiter_if;
    import sdram_arb_pkg::*;

    logic              r0_request,    r1_request;
    logic              r0_write,      r1_write;
    logic [ADDR_W-1:0] r0_address,    r1_address;
    logic [DATA_W-1:0] r0_writedata,  r1_writedata;
    logic [BE_W-1:0]   r0_byteenable, r1_byteenable;
    logic              r0_done,       r1_done;
    logic [DATA_W-1:0] r0_readdata,   r1_readdata;
    logic              r0_error,      r1_error;

    logic [ADDR_W-1:0] sdram_addr;
    logic [BE_W-1:0]   sdram_byteenable_n;
    logic              sdram_chipselect;
    logic [DATA_W-1:0] sdram_writedata;
    logic              sdram_read_n;
    logic              sdram_write_n;
    logic [DATA_W-1:0] sdram_readdata;
    logic              sdram_readdata_valid;
    logic              sdram_waitrequest;

    // Arbiter side.
    modport slave (
        input  r0_request, r0_write, r0_address, r0_writedata, r0_byteenable,
        input  r1_request, r1_write, r1_address, r1_writedata, r1_byteenable,
        output r0_done, r0_readdata, r0_error,
        output r1_done, r1_readdata, r1_error,
        output sdram_addr, sdram_byteenable_n, sdram_chipselect,
        output sdram_writedata, sdram_read_n, sdram_write_n,
        input  sdram_readdata, sdram_readdata_valid, sdram_waitrequest
    );

    // Requesters plus memory side.
    modport master (
        output r0_request, r0_write, r0_address, r0_writedata, r0_byteenable,
        output r1_request, r1_write, r1_address, r1_writedata, r1_byteenable,
        input  r0_done, r0_readdata, r0_error,
        input  r1_done, r1_readdata, r1_error,
        input  sdram_addr, sdram_byteenable_n, sdram_chipselect,
        input  sdram_writedata, sdram_read_n, sdram_write_n,
        output sdram_readdata, sdram_readdata_valid, sdram_waitrequest
    );

endinterface

// File: rtl/sdram_arb_grant.sv
// Two-input grant selection with last-grant memory for round-robin ties.
module sdram_arb_grant #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] request,
    input  logic       take,
    output logic       grant_idx,
    output logic       grant_vld
);

    logic last_grant;

    // Pick a port: single requester wins outright, ties go by policy.
    always_comb begin
        grant_vld = |request;
        grant_idx = request[1];
        if (request == 2'b11)
            grant_idx = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
    end

    // Remember who was granted; reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     last_grant <= 1'b1;
        else if (take) last_grant <= grant_idx;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter onto a single Avalon-MM SDRAM port, one transaction
// outstanding, with a read-data timeout.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 64
) (
    input  logic            clock,
    input  logic            reset,
    sdram_arbiter_if.slave  bus
);

    arb_state_t                  state, state_nxt;
    arb_req_t [NUM_PORTS-1:0]    req_in;
    logic     [NUM_PORTS-1:0]    req_vec;
    arb_req_t                    cur;
    logic                        cur_port;
    logic                        gnt_idx, gnt_vld, take;
    logic [CNT_W-1:0]            wait_cnt;
    logic                        timeout_hit, enter_done, issuing;
    logic [DATA_W-1:0]           fin_data;
    logic                        fin_err;
    logic [NUM_PORTS-1:0]        done_q, err_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q;

    assign req_vec   = {bus.r1_request, bus.r0_request};
    assign req_in[0] = '{write: bus.r0_write, addr: bus.r0_address,
                         wdata: bus.r0_writedata, be: bus.r0_byteenable};
    assign req_in[1] = '{write: bus.r1_write, addr: bus.r1_address,
                         wdata: bus.r1_writedata, be: bus.r1_byteenable};

    sdram_arb_grant #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_grant (
        .clock     (clock),
        .reset     (reset),
        .request   (req_vec),
        .take      (take),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    assign take        = (state == IDLE) && gnt_vld;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign enter_done  = (state != DONE) && (state_nxt == DONE);
    assign issuing     = (state == ISSUE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus the completion result that is written on entry to DONE.
    always_comb begin
        state_nxt = state;
        fin_data  = '0;
        fin_err   = 1'b0;
        case (state)
            IDLE:     if (gnt_vld) state_nxt = ISSUE;
            ISSUE:    if (!bus.sdram_waitrequest)
                          state_nxt = cur.write ? DONE : WAITDATA;
            WAITDATA: begin
                if (bus.sdram_readdata_valid) begin
                    state_nxt = DONE;
                    fin_data  = bus.sdram_readdata;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    fin_err   = 1'b1;
                end
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Latch the granted command and run the read-wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            cur_port <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (take) begin
                cur      <= req_in[gnt_idx];
                cur_port <= gnt_idx;
            end
            wait_cnt <= (state == WAITDATA && state_nxt == WAITDATA) ?
                        wait_cnt + 1'b1 : '0;
        end
    end

    // Strobes only during ISSUE; address and data simply hold the latched copy.
    assign bus.sdram_chipselect   = issuing;
    assign bus.sdram_read_n       = issuing ? cur.write  : 1'b1;
    assign bus.sdram_write_n      = issuing ? ~cur.write : 1'b1;
    assign bus.sdram_byteenable_n = issuing ? ~cur.be    : 2'b11;
    assign bus.sdram_addr         = cur.addr;
    assign bus.sdram_writedata    = cur.wdata;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic              done_r, err_r;
        logic [DATA_W-1:0] rdata_r;

        // Per-port completion pulse and sticky result.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                done_r  <= 1'b0;
                err_r   <= 1'b0;
                rdata_r <= '0;
            end else begin
                done_r <= enter_done && (cur_port == 1'(p));
                if (enter_done && (cur_port == 1'(p))) begin
                    rdata_r <= fin_data;
                    err_r   <= fin_err;
                end
            end
        end

        assign done_q[p]  = done_r;
        assign err_q[p]   = err_r;
        assign rdata_q[p] = rdata_r;
    end

    assign bus.r0_done     = done_q[0];
    assign bus.r1_done     = done_q[1];
    assign bus.r0_error    = err_q[0];
    assign bus.r1_error    = err_q[1];
    assign bus.r0_readdata = rdata_q[0];
    assign bus.r1_readdata = rdata_q[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: round-robin and fixed-priority instances
// share one stimulus stream.
module tb_sdram_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [1:0]       req = '0, wr = '0;
    logic [1:0][25:0] addr = '0;
    logic [1:0][15:0] wdata = '0;
    logic [1:0][1:0]  be = '0;
    logic             waitreq = 1'b0, valid = 1'b0;
    logic [15:0]      rdin = '0;

    sdram_arbiter_if bus[2] ();

    for (genvar i = 0; i < 2; i++) begin : g_wire
        assign bus[i].r0_request = req[0];    assign bus[i].r1_request = req[1];
        assign bus[i].r0_write = wr[0];       assign bus[i].r1_write = wr[1];
        assign bus[i].r0_address = addr[0];   assign bus[i].r1_address = addr[1];
        assign bus[i].r0_writedata = wdata[0]; assign bus[i].r1_writedata = wdata[1];
        assign bus[i].r0_byteenable = be[0];  assign bus[i].r1_byteenable = be[1];
        assign bus[i].sdram_readdata = rdin;
        assign bus[i].sdram_readdata_valid = valid;
        assign bus[i].sdram_waitrequest = waitreq;
    end

    sdram_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT(64)) dut0 (
        .clock(clock), .reset(reset), .bus(bus[0]));
    sdram_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT(64)) dut1 (
        .clock(clock), .reset(reset), .bus(bus[1]));

    logic [1:0]       dn0, dn1, er0;
    logic [1:0][15:0] rd0;
    logic             cs, rn, wn;
    logic [1:0]       ben;
    logic [25:0]      sa;
    logic [15:0]      swd;
    assign dn0 = {bus[0].r1_done, bus[0].r0_done};
    assign dn1 = {bus[1].r1_done, bus[1].r0_done};
    assign er0 = {bus[0].r1_error, bus[0].r0_error};
    assign rd0 = {bus[0].r1_readdata, bus[0].r0_readdata};
    assign cs  = bus[0].sdram_chipselect;
    assign rn  = bus[0].sdram_read_n;
    assign wn  = bus[0].sdram_write_n;
    assign ben = bus[0].sdram_byteenable_n;
    assign sa  = bus[0].sdram_addr;
    assign swd = bus[0].sdram_writedata;

    typedef struct {
        logic        port;
        logic        wr;
        logic [25:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          wait_cyc;   // ISSUE cycles with waitrequest high
        int          vdelay;     // valid in this WAITDATA cycle (1-based), 0 = never
        logic        noise;      // drive a bogus valid during ISSUE
        logic [15:0] rdata;
        int          exp_lat;    // negedges from request edge to done seen
        int          exp_issue;
        logic        exp_wn;
        logic        exp_rn;
        logic [1:0]  exp_ben;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];
    vec_t tout;

    int tests = 0;
    int fails = 0;

    int          m_lat, m_issue;
    logic        m_seen, m_other, m_wn, m_rn, m_er;
    logic [1:0]  m_ben, m_after;
    logic [25:0] m_a;
    logic [15:0] m_wd, m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Issue one transaction from v.port and play the memory side.
    task automatic run_txn(input vec_t v);
        int w;
        w = 0;
        m_issue = 0; m_seen = 1'b0; m_other = 1'b0; m_lat = 0;
        @(negedge clock);
        req[v.port] = 1'b1; wr[v.port] = v.wr; addr[v.port] = v.addr;
        wdata[v.port] = v.wdata; be[v.port] = v.be;
        for (int c = 1; c <= 200 && !m_seen; c++) begin
            @(negedge clock);
            if (dn0[v.port]) begin
                m_seen = 1'b1; m_lat = c;
                m_rd = rd0[v.port]; m_er = er0[v.port];
            end else if (cs) begin
                m_issue++;
                m_wn = wn; m_rn = rn; m_ben = ben; m_a = sa; m_wd = swd;
                req[v.port] = 1'b0; wr[v.port] = ~v.wr; addr[v.port] = ~v.addr;
                wdata[v.port] = ~v.wdata; be[v.port] = ~v.be;
                waitreq = (m_issue <= v.wait_cyc);
                valid = v.noise; rdin = 16'hDEAD;
            end else if (m_issue > 0) begin
                w++;
                valid = (w == v.vdelay);
                rdin  = valid ? v.rdata : 16'h0BAD;
            end
            if (dn0[~v.port]) m_other = 1'b1;
        end
        valid = 1'b0; waitreq = 1'b0;
        @(negedge clock);
        m_after = dn0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        run_txn(v);
        check({tag, " done seen"}, 32'(m_seen), 32'd1);
        check({tag, " latency"}, m_lat, v.exp_lat);
        check({tag, " issue cycles"}, m_issue, v.exp_issue);
        check({tag, " write_n"}, 32'(m_wn), 32'(v.exp_wn));
        check({tag, " read_n"}, 32'(m_rn), 32'(v.exp_rn));
        check({tag, " byteenable_n"}, 32'(m_ben), 32'(v.exp_ben));
        check({tag, " addr"}, 32'(m_a), 32'(v.addr));
        check({tag, " writedata"}, 32'(m_wd), 32'(v.wdata));
        check({tag, " error"}, 32'(m_er), 32'(v.exp_err));
        if (!v.wr) check({tag, " readdata"}, 32'(m_rd), 32'(v.exp_rd));
        check({tag, " other port done"}, 32'(m_other), 32'd0);
        check({tag, " done one cycle"}, 32'(m_after), 32'd0);
    endtask

    initial begin
        int n0, n1;
        logic [3:0] g0, g1;

        //         port wr addr         wdata     be     wt vd nz rdata     lat iss wn rn ben    rd        err
        vecs[0] = '{1'b0, 1'b1, 26'h0000123, 16'hBEEF, 2'b11, 0, 0, 1'b0, 16'h0000, 2, 1, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 26'h3FFFFFF, 16'h0000, 2'b11, 3, 4, 1'b0, 16'h5A5A, 9, 4, 1'b1, 1'b0, 2'b00, 16'h5A5A, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 26'h2AAAAAA, 16'h1234, 2'b01, 2, 0, 1'b0, 16'h0000, 4, 3, 1'b0, 1'b1, 2'b10, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 26'h0000000, 16'hFFFF, 2'b10, 0, 0, 1'b1, 16'h0000, 2, 1, 1'b0, 1'b1, 2'b01, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 26'h1555555, 16'h0F0F, 2'b11, 0, 1, 1'b1, 16'hA5C3, 3, 1, 1'b1, 1'b0, 2'b00, 16'hA5C3, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 26'h0C0FFEE, 16'h0000, 2'b01, 1, 2, 1'b1, 16'h0001, 5, 2, 1'b1, 1'b0, 2'b10, 16'h0001, 1'b0};
        tout    = '{1'b0, 1'b0, 26'h0ABCDEF, 16'h0000, 2'b11, 0, 0, 1'b0, 16'h0000, 66, 1, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1};

        // Reset values.
        @(negedge clock); @(negedge clock);
        check("rst chipselect", 32'(cs), 32'd0);
        check("rst read_n", 32'(rn), 32'd1);
        check("rst write_n", 32'(wn), 32'd1);
        check("rst byteenable_n", 32'(ben), 32'h3);
        check("rst addr", 32'(sa), 32'd0);
        check("rst writedata", 32'(swd), 32'd0);
        check("rst done", 32'(dn0), 32'd0);
        check("rst readdata", 32'(rd0), 32'd0);
        check("rst error", 32'(er0), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) apply(vecs[i], $sformatf("v%0d", i));
        check("r0 readdata held", 32'(rd0[0]), 32'hA5C3);

        // Read that never gets valid; a late valid must not be captured.
        apply(tout, "timeout");
        valid = 1'b1; rdin = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("late valid done %0d", i), 32'(dn0), 32'd0);
        end
        valid = 1'b0;
        check("late valid readdata", 32'(rd0[0]), 32'd0);
        check("late valid error", 32'(er0[0]), 32'd1);

        // Reset while waiting for read data.
        check("r1 readdata before rst", 32'(rd0[1]), 32'h0001);
        @(negedge clock);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 26'h0000777; be[1] = 2'b11;
        @(negedge clock);
        check("wd issue", 32'(cs), 32'd1);
        req[1] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("wd in waitdata", 32'(cs), 32'd0);
        reset = 1'b1;
        #1;
        check("wd rst read_n", 32'(rn), 32'd1);
        check("wd rst addr", 32'(sa), 32'd0);
        check("wd rst readdata", 32'(rd0[1]), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check($sformatf("wd rst no done %0d", i), 32'(dn0), 32'd0);
        end
        reset = 1'b0;

        // Reset while a write is stalled in ISSUE: strobes drop at once.
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 26'h0000456; be[0] = 2'b11; waitreq = 1'b1;
        @(negedge clock);
        check("is issue", 32'(cs), 32'd1);
        req[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("is rst chipselect", 32'(cs), 32'd0);
        check("is rst write_n", 32'(wn), 32'd1);
        check("is rst byteenable_n", 32'(ben), 32'h3);
        @(negedge clock);
        reset = 1'b0; waitreq = 1'b0;
        check("is rst no done", 32'(dn0), 32'd0);
        apply(vecs[3], "post-reset");

        // Continuous reads from both ports, starting from reset state.
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        req = 2'b11; wr = 2'b00; waitreq = 1'b0; valid = 1'b1; rdin = 16'h3C3C;
        n0 = 0; n1 = 0; g0 = '0; g1 = '0;
        for (int c = 0; c < 100 && (n0 < 4 || n1 < 4); c++) begin
            @(negedge clock);
            if (n0 < 4 && dn0 != 2'b00) begin g0[n0] = dn0[1]; n0++; end
            if (n1 < 4 && dn1 != 2'b00) begin g1[n1] = dn1[1]; n1++; end
        end
        req = 2'b00; valid = 1'b0;
        check("rr grant count", n0, 4);
        check("fixed grant count", n1, 4);
        check("rr grant order", 32'(g0), 32'b1010);
        check("fixed grant order", 32'(g1), 32'b0000);
        check("rr readdata", 32'(rd0[0]), 32'h3C3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, meaning: 1 = port 0 always wins a tie; 0 = round-robin.
REQ-002 Parameter TIMEOUT, default 64, meaning: max cycles in WAITDATA before the transaction is aborted; range 2..255.
REQ-003 Port clock  input  1  single system clock (50 MHz domain); all logic on posedge clock.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Ports rN_request  input  1  level request from port N, N in {0,1}.
REQ-006 Ports rN_write  input  1  1 = write, 0 = read.
REQ-007 Ports rN_address  input  26  word address.
REQ-008 Ports rN_writedata  input  16  write data.
REQ-009 Ports rN_byteenable  input  2  active-high byte enables.
REQ-010 Ports rN_done  output  1  one-cycle completion pulse.
REQ-011 Ports rN_readdata  output  16  read result, valid with rN_done.
REQ-012 Ports rN_error  output  1  timeout flag, valid with rN_done.
REQ-013 Port sdram_addr  output  26  Avalon-MM address.
REQ-014 Port sdram_byteenable_n  output  2  active-low byte enables.
REQ-015 Port sdram_chipselect  output  1  transfer select.
REQ-016 Port sdram_writedata  output  16  write data.
REQ-017 Ports sdram_read_n and sdram_write_n  output  1 each  active-low strobes.
REQ-018 Ports sdram_readdata  input  16, sdram_readdata_valid  input  1, sdram_waitrequest  input  1.

Function
REQ-019 FSM states: IDLE, ISSUE, WAITDATA, DONE; one transaction outstanding at a time.
REQ-020 IDLE: if any rN_request is high, grant one port, latch its write/address/writedata/byteenable, and go to ISSUE.
REQ-021 Tie rule, FIXED_PRIORITY=0: grant the port not granted last; last-grant register resets to 1, so port 0 wins the first tie.
REQ-022 Tie rule, FIXED_PRIORITY=1: port 0 wins every tie.
REQ-023 ISSUE outputs: chipselect=1; read_n=latched write; write_n=~latched write; addr, writedata and byteenable_n=~byteenable come from the latched values; hold all while sdram_waitrequest=1.
REQ-024 ISSUE exit on an edge with waitrequest=0: write goes to DONE; read goes to WAITDATA.
REQ-025 Outside ISSUE: chipselect=0, read_n=1, write_n=1, byteenable_n=2'b11; addr and writedata hold their last values.
REQ-026 WAITDATA: on sdram_readdata_valid=1, capture sdram_readdata, error=0, go to DONE.
REQ-027 WAITDATA timeout: a counter clears on entry; when it reaches TIMEOUT-1 without valid, go to DONE with readdata=0 and error=1.
REQ-028 sdram_readdata_valid outside WAITDATA is ignored, and no capture occurs.
REQ-029 DONE: assert rN_done for exactly one cycle on the granted port only, with rN_readdata and rN_error valid; then go to IDLE.
REQ-030 rN_readdata and rN_error hold until the next done on the same port.
REQ-031 Requests are not sampled in ISSUE, WAITDATA or DONE.
REQ-032 A request still high in the IDLE cycle after done starts a new transaction; a requester that wants one transaction drops request on the cycle its done is seen.
REQ-033 Latency, write with waitrequest=0: request sampled in IDLE at edge k, ISSUE during k..k+1, rN_done high during cycle k+2.
REQ-034 Latency, read: rN_done is high the cycle after valid is sampled.
REQ-035 Request inputs may change freely after grant; the latched copy is used.

Reset
REQ-036 reset=1: state=IDLE immediately, asynchronously.
REQ-037 reset=1 output values: chipselect=0, read_n=1, write_n=1, byteenable_n=2'b11, addr=0, writedata=0, rN_done=0, rN_readdata=0, rN_error=0; last-grant=1; timeout counter=0.
REQ-038 Reset mid-transaction aborts it with no done pulse.

Structure
REQ-039 Package sdram_arb_pkg holds the state enum, ADDR_W=26 and DATA_W=16.
REQ-040 Sub-module sdram_arb_grant holds the two-input grant logic and the last-grant register; it outputs grant index and grant-valid.

Verification
REQ-041 Write, no wait: r0 write addr 0x0000123, data 0xBEEF, be=2'b11 -> one ISSUE cycle with write_n=0, byteenable_n=2'b00; r0_done 2 cycles after request; r0_error=0.
REQ-042 Read with waitrequest held 3 cycles, valid 4 cycles after ISSUE exit with data 0x5A5A -> read_n=0 held 4 cycles; r1_readdata=0x5A5A with r1_done.
REQ-043 Both ports request continuous reads, FIXED_PRIORITY=0 -> grants alternate 0,1,0,1; FIXED_PRIORITY=1 -> port 1 never granted while r0_request is high.
REQ-044 Read, valid never asserted, TIMEOUT=64 -> done 64 cycles after WAITDATA entry; readdata=0; error=1; a valid arriving later is ignored.
REQ-045 Reset asserted in WAITDATA -> strobes deasserted the same cycle; no rN_done; after release a new request completes normally.
